// File: rtl/clk_pulse_pkg.sv
// clk_pulse_pkg: shared state/mode enums and default widths for the multi-channel pulse generator
package clk_pulse_pkg;
  typedef enum logic {IDLE, RUN} pulse_state_t;
  typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} pulse_mode_t;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/clk_pulse_ch.sv
// clk_pulse_ch: one pulse channel; ports clk, reset (sync active-low), en/oneshot/start/load, divisor -> out, busy, pulse_cnt (MULTI_CLK_PULSE_CNT_EN only)
module clk_pulse_ch
  import clk_pulse_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             oneshot,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] divisor,
  output logic             out,
  output logic             busy
`ifdef MULTI_CLK_PULSE_CNT_EN
  ,
  output logic [CNT_W-1:0] pulse_cnt
`endif
);
  pulse_state_t     state, state_n;
  pulse_mode_t      mode;
  logic [WIDTH-1:0] cnt, cnt_n, div_q, div_n, pend_q;
  logic             pend_v, term, out_n;
  if (WIDTH < 2 || CNT_W < 1) begin : g_bad_param
    $error("clk_pulse_ch: WIDTH must be >= 2 and CNT_W >= 1");
  end
  assign mode = pulse_mode_t'(oneshot);
  assign term = en && state == RUN && cnt == div_q;
  assign busy = state == RUN;
  always_ff @(posedge clk) state <= reset ? state_n : IDLE;
  always_comb
    state_n = !en ? IDLE
            : state == IDLE ? ((mode == MODE_ONESHOT && !start) ? IDLE : RUN)
            : (term && mode == MODE_ONESHOT) ? IDLE : RUN;
  // a pending divisor only lands on a period boundary; a load on that same edge wins
  always_comb begin
    out_n = term;
    cnt_n = (state == RUN && en && !term) ? cnt + 1'b1 : '0;
    div_n = (state == IDLE && load) ? divisor
          : !term ? div_q
          : load ? divisor
          : pend_v ? pend_q : div_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      div_q  <= '0;
      pend_q <= '0;
      pend_v <= 1'b0;
      out    <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      div_q  <= div_n;
      out    <= out_n;
      pend_q <= load ? divisor : pend_q;
      pend_v <= !term && (load || pend_v);
    end
  end
`ifdef MULTI_CLK_PULSE_CNT_EN
  always_ff @(posedge clk) pulse_cnt <= (!reset || !en) ? '0 : pulse_cnt + CNT_W'(out_n);
`endif
endmodule

// File: rtl/multi_clk_pulse.sv
// multi_clk_pulse: NUM_CH independent divisor pulse channels; ports clk, reset (sync active-low), en/oneshot/start/load, divisor_in -> out, busy, pulse_cnt (MULTI_CLK_PULSE_CNT_EN only)
module multi_clk_pulse
  import clk_pulse_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       oneshot,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] divisor_in,
  output logic [NUM_CH-1:0]       out,
  output logic [NUM_CH-1:0]       busy
`ifdef MULTI_CLK_PULSE_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] pulse_cnt
`endif
);
  if (NUM_CH < 1) begin : g_bad_param
    $error("multi_clk_pulse: NUM_CH must be >= 1");
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_pulse_ch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .oneshot (oneshot[i]),
      .start   (start[i]),
      .load    (load[i]),
      .divisor (divisor_in[i*WIDTH +: WIDTH]),
      .out     (out[i]),
      .busy    (busy[i])
`ifdef MULTI_CLK_PULSE_CNT_EN
      ,
      .pulse_cnt (pulse_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end
endmodule

// File: tb/tb_multi_clk_pulse.sv
// tb_multi_clk_pulse: table and scoreboard checks of out/busy for the pulse generator
module tb_multi_clk_pulse;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  en, oneshot, start, load, out, busy;
  logic [7:0]  dv [4];
  logic [31:0] divisor_in;
`ifdef MULTI_CLK_PULSE_CNT_EN
  logic [15:0] pulse_cnt;
`endif
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] xo;
    logic [3:0] xb;
    string      nm;
  } exp_t;
  typedef struct {
    logic [3:0] en, os, st, ld, xo, xb;
    string      nm;
  } vec_t;

  exp_t q[$];
  vec_t tbl[13];

  assign divisor_in = {dv[3], dv[2], dv[1], dv[0]};
  always #5 clk = ~clk;

  multi_clk_pulse #(.NUM_CH(4), .WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .oneshot    (oneshot),
    .start      (start),
    .load       (load),
    .divisor_in (divisor_in),
    .out        (out),
    .busy       (busy)
`ifdef MULTI_CLK_PULSE_CNT_EN
    ,
    .pulse_cnt  (pulse_cnt)
`endif
  );

  task automatic cyc(input logic r, input logic [3:0] e, o, s, l, xo, xb, input string nm);
    exp_t x;
    reset = r; en = e; oneshot = o; start = s; load = l;
    q.push_back('{xo, xb, nm});
    @(posedge clk);
    #1;
    x = q.pop_front();
    checks++;
    if (out !== x.xo) begin
      failures++;
      $display("FAIL %s out got=%b want=%b", x.nm, out, x.xo);
    end
    checks++;
    if (busy !== x.xb) begin
      failures++;
      $display("FAIL %s busy got=%b want=%b", x.nm, busy, x.xb);
    end
  endtask

`ifdef MULTI_CLK_PULSE_CNT_EN
  task automatic pc_check(input logic [3:0] want, input string nm);
    checks++;
    if (pulse_cnt[15:12] !== want) begin
      failures++;
      $display("FAIL %s pulse_cnt3 got=%0d want=%0d", nm, pulse_cnt[15:12], want);
    end
  endtask
`endif

  initial begin
    foreach (dv[i]) dv[i] = 8'd0;
    tbl[0]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0000, "t_load_idle"};
    tbl[1]  = '{4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "t_enter"};
    tbl[2]  = '{4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0011, "t_start"};
    tbl[3]  = '{4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0011, "t_c2"};
    tbl[4]  = '{4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0011, "t_retrig"};
    tbl[5]  = '{4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0011, "t_c4"};
    tbl[6]  = '{4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 4'b0001, "t_pulse1"};
    tbl[7]  = '{4'b0011, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0001, "t_start_en0"};
    tbl[8]  = '{4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "t_c7"};
    tbl[9]  = '{4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "t_c8"};
    tbl[10] = '{4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "t_c9"};
    tbl[11] = '{4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0001, "t_pulse2"};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "t_off"};

    cyc(0, 0, 0, 0, 0, 0, 0, "reset_a");
    cyc(0, 4'hf, 0, 4'hf, 0, 0, 0, "reset_b");
`ifdef MULTI_CLK_PULSE_CNT_EN
    pc_check(4'd0, "pc_reset");
`endif

    dv[0] = 8'd4; dv[1] = 8'd3;
    foreach (tbl[i]) cyc(1, tbl[i].en, tbl[i].os, tbl[i].st, tbl[i].ld, tbl[i].xo, tbl[i].xb, tbl[i].nm);

    dv[2] = 8'd9;
    cyc(1, 0, 0, 0, 4'b0100, 0, 0, "rl_load");
    cyc(1, 4'b0100, 0, 0, 0, 0, 4'b0100, "rl_enter");
    for (int k = 1; k <= 19; k++) begin
      logic p;
      p = (k <= 10) ? (k == 10) : ((k - 10) % 3 == 0);
      if (k == 6) dv[2] = 8'd2;
      cyc(1, 4'b0100, 0, 0, (k == 6) ? 4'b0100 : 4'b0000, p ? 4'b0100 : 4'b0000, 4'b0100, $sformatf("rl_k%0d", k));
    end
    cyc(1, 0, 0, 0, 0, 0, 0, "rl_off");

    dv[3] = 8'd0;
    cyc(1, 0, 0, 0, 4'b1000, 0, 0, "d0_load");
    cyc(1, 4'b1000, 0, 0, 0, 0, 4'b1000, "d0_enter");
    for (int k = 1; k <= 3; k++) cyc(1, 4'b1000, 0, 0, 0, 4'b1000, 4'b1000, $sformatf("d0_hold%0d", k));
    cyc(1, 0, 0, 0, 0, 0, 0, "d0_drop");

    cyc(1, 4'b0001, 0, 0, 0, 0, 4'b0001, "ed_enter");
    cyc(1, 4'b0001, 0, 0, 0, 0, 4'b0001, "ed_c1");
    cyc(1, 4'b0001, 0, 0, 0, 0, 4'b0001, "ed_c2");
    cyc(1, 0, 0, 0, 0, 0, 0, "ed_drop");
    cyc(1, 4'b0001, 0, 0, 0, 0, 4'b0001, "ed_reenter");
    for (int k = 1; k <= 9; k++) cyc(1, 4'b0001, 0, 0, 0, (k == 5) ? 4'b0001 : 4'b0000, 4'b0001, $sformatf("ed_k%0d", k));
    cyc(0, 4'b0001, 0, 0, 0, 0, 0, "rst_on_term");
    cyc(1, 4'b0001, 0, 0, 0, 0, 4'b0001, "rst_reenter");
    cyc(1, 4'b0001, 0, 0, 0, 4'b0001, 4'b0001, "rst_div_zero");
    cyc(1, 0, 0, 0, 0, 0, 0, "rst_off");

`ifdef MULTI_CLK_PULSE_CNT_EN
    cyc(1, 4'b1000, 0, 0, 0, 0, 4'b1000, "pc_enter");
    for (int k = 1; k <= 20; k++) cyc(1, 4'b1000, 0, 0, 0, 4'b1000, 4'b1000, $sformatf("pc_k%0d", k));
    pc_check(4'd4, "pc_wrap");
    cyc(1, 0, 0, 0, 0, 0, 0, "pc_drop");
    pc_check(4'd0, "pc_clear");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_clk_pulse.md
Name: multi_clk_pulse

Overview:
- Parametrised multi-channel pulse/tick generator; successor to the single-channel divisor pulser.
- Each of NUM_CH channels emits a one-cycle pulse every (divisor+1) clk cycles.
- Adds per-channel enable, periodic/one-shot mode, glitch-free divisor reload at period boundary, and busy status.
- Drives timebases for display refresh, debounce sampling, game-tick and sequencing logic.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
WIDTH, 32, divisor/counter width per channel (>=2)
CNT_W, 16, pulse-counter width (used only with PULSE_CNT_EN)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset
en  input  NUM_CH  per-channel enable, level
oneshot  input  NUM_CH  per-channel mode: 0 = periodic, 1 = one-shot
start  input  NUM_CH  one-shot trigger, sampled only in IDLE with en=1 and oneshot=1
load  input  NUM_CH  latch divisor_in slice into channel pending register
divisor_in  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
out  output  NUM_CH  registered pulse outputs
busy  output  NUM_CH  1 while channel is in RUN
pulse_cnt  output  NUM_CH*CNT_W  pulses emitted per channel (PULSE_CNT_EN only)

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, cnt=0, div_q=0, pend_q=0, pend_v=0, out=0, busy=0, pulse_cnt=0. Reset overrides every other input, including a run in progress.
- Per channel, two states: IDLE and RUN. busy = (state==RUN), registered.
- IDLE->RUN, cnt<=0:
  - periodic mode: on any edge with en=1;
  - one-shot mode: on an edge with en=1 and start=1.
- RUN, cnt<div_q: cnt<=cnt+1, out<=0.
- RUN, cnt==div_q (terminal): out<=1, cnt<=0.
  - One-shot channels then go to IDLE.
  - Periodic channels stay in RUN.
- Timing: first pulse goes high after the (div_q+1)-th edge following the entry edge; period is exactly div_q+1 cycles; pulse width is 1 cycle.
- div_q==0 in periodic mode: out stays high continuously while running.
- en=0 at any edge: state<=IDLE, cnt<=0, out<=0 on that edge. Re-enable restarts the phase from zero.
- Divisor reload:
  - load=1 captures divisor_in into pend_q and sets pend_v.
  - In IDLE, div_q<=divisor_in on the same edge.
  - In RUN, div_q<=pend_q at the next terminal edge, and pend_v clears.
  - A second load before the boundary overwrites pend_q; the last one wins.
  - If load coincides with a terminal edge, the new value applies immediately for the next period.
- oneshot is sampled at the terminal edge; a mode change mid-period takes effect there.
- start while RUN is ignored (no retrigger). start with en=0 is ignored.
- The counter never exceeds div_q; no wrap occurs. Unsigned comparison at full WIDTH.
- Channels are fully independent; no shared state.

Optional Feature:
- Macro: MULTI_CLK_PULSE_CNT_EN.
- Defined: per-channel CNT_W-bit pulse_cnt increments on every edge that sets out<=1. It wraps modulo 2^CNT_W and clears on reset or when en=0.
- Undefined: pulse_cnt port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package clk_pulse_pkg holds:
  - typedef enum logic {IDLE, RUN} pulse_state_t;
  - typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} pulse_mode_t;
  - default WIDTH/CNT_W localparams.
- Sub-module clk_pulse_ch implements one channel (WIDTH, CNT_W parameters). The top level generate-instantiates NUM_CH copies and slices the buses.

Test Plan:
- Periodic: reset released, load ch0 with 4 while IDLE, en0=1 → out0 high for 1 cycle every 5 cycles, first pulse after the 5th edge after enable; busy0=1 throughout.
- One-shot: ch1 divisor 3, oneshot1=1, en1=1, start pulse → exactly one pulse 4 edges later, busy1 falls with it; a start during RUN produces no extra pulse.
- Reload: ch2 running at divisor 9, load 2 mid-period (cnt=5) → the current period completes at 10 cycles, subsequent periods are 3 cycles, with no short or merged pulse.
- Boundaries: divisor 0 periodic → out held high; en dropped mid-count → out=0 and busy=0 next edge, and on re-enable the phase restarts (first pulse after div_q+1 edges).
- Reset mid-run: assert reset=0 on a terminal edge → out=0, busy=0, div_q=0 afterwards; no pulse emitted.
- With MULTI_CLK_PULSE_CNT_EN and CNT_W=4: run divisor 0 for 20 cycles → pulse_cnt wraps 15→0 and reads 4 at the end; clears when en drops.
